// File: rtl/binary_channel_persist.sv
// Per-channel signed energy-vs-scaled-baseline comparator with run-length
// hysteresis on each decision and a registered k-of-N vote across channels.
module binary_channel_persist #(
    parameter int NUM_FEAT  = 6,
    parameter int OUT_W     = 72,
    parameter int BASE_W    = 50,
    parameter int SCALE_W   = 8,
    parameter int DEF_SCALE = 1,
    parameter int PERSIST   = 4,
    parameter int VOTE_K    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_FEAT*OUT_W-1:0]   feat_out,
    input  logic [NUM_FEAT*BASE_W-1:0]  feat_base,
    input  logic [NUM_FEAT-1:0]         feat_valid,
    input  logic                        cfg_load,
    input  logic [NUM_FEAT*SCALE_W-1:0] cfg_scale,
    output logic [NUM_FEAT-1:0]         raw_binary,
    output logic [NUM_FEAT-1:0]         raw_valid,
    output logic [NUM_FEAT-1:0]         det_binary,
    output logic [NUM_FEAT-1:0]         det_valid,
    output logic                        vote_out,
    output logic                        vote_valid
);

    localparam int PROD_W = BASE_W + SCALE_W + 1;
    localparam int CMP_W  = ((OUT_W > PROD_W) ? OUT_W : PROD_W) + 1;
    localparam int CNT_W  = $clog2(PERSIST + 1);
    localparam int POP_W  = $clog2(NUM_FEAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST - 1);
    localparam logic [POP_W-1:0] VOTE_MIN = POP_W'(VOTE_K);

    logic        [SCALE_W-1:0] scale_q  [NUM_FEAT];
    logic        [CNT_W-1:0]   run_cnt  [NUM_FEAT];
    logic signed [PROD_W-1:0]  base_x   [NUM_FEAT];
    logic signed [PROD_W-1:0]  scale_x  [NUM_FEAT];
    logic signed [PROD_W-1:0]  prod     [NUM_FEAT];
    logic signed [CMP_W-1:0]   out_ext  [NUM_FEAT];
    logic signed [CMP_W-1:0]   thr_ext  [NUM_FEAT];
    logic        [NUM_FEAT-1:0] ge;
    logic        [POP_W-1:0]   det_pop;

    // Operands are widened to the product width first so the signed multiply
    // is exact; scale is zero-extended so it is never read as negative.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FEAT; i++) begin
            base_x[i]  = {{(PROD_W-BASE_W){feat_base[i*BASE_W+BASE_W-1]}},
                          feat_base[i*BASE_W +: BASE_W]};
            scale_x[i] = {{(PROD_W-SCALE_W){1'b0}}, scale_q[i]};
            prod[i]    = base_x[i] * scale_x[i];
            out_ext[i] = {{(CMP_W-OUT_W){feat_out[i*OUT_W+OUT_W-1]}},
                          feat_out[i*OUT_W +: OUT_W]};
            thr_ext[i] = {{(CMP_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
            ge[i]      = (out_ext[i] >= thr_ext[i]);
        end
    end

    always_comb begin
        det_pop = '0;
        for (int unsigned i = 0; i < NUM_FEAT; i++) begin
            det_pop = det_pop + POP_W'(det_binary[i]);
        end
    end

    // Scale registers and stage 1: raw comparison against the current scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_FEAT; i++) begin
                scale_q[i] <= SCALE_W'(DEF_SCALE);
            end
            raw_binary <= '0;
            raw_valid  <= '0;
        end else begin
            if (cfg_load) begin
                for (int unsigned i = 0; i < NUM_FEAT; i++) begin
                    scale_q[i] <= cfg_scale[i*SCALE_W +: SCALE_W];
                end
            end
            raw_valid <= feat_valid;
            for (int unsigned i = 0; i < NUM_FEAT; i++) begin
                if (feat_valid[i]) begin
                    raw_binary[i] <= ge[i];
                end
            end
        end
    end

    // Stage 2: debounce. A config load wipes the hysteresis state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_FEAT; i++) begin
                run_cnt[i] <= '0;
            end
            det_binary <= '0;
            det_valid  <= '0;
        end else begin
            det_valid <= raw_valid;
            for (int unsigned i = 0; i < NUM_FEAT; i++) begin
                if (cfg_load) begin
                    det_binary[i] <= 1'b0;
                    run_cnt[i]    <= '0;
                end else if (raw_valid[i]) begin
                    if (raw_binary[i] == det_binary[i]) begin
                        run_cnt[i] <= '0;
                    end else if (run_cnt[i] == CNT_LAST) begin
                        det_binary[i] <= ~det_binary[i];
                        run_cnt[i]    <= '0;
                    end else begin
                        run_cnt[i] <= run_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Stage 3: one vote per cycle in which any channel was re-evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_out   <= 1'b0;
            vote_valid <= 1'b0;
        end else begin
            vote_valid <= |det_valid;
            if (|det_valid) begin
                vote_out <= (det_pop >= VOTE_MIN);
            end
        end
    end

endmodule
